// File: rtl/conv2d_mac.sv
// 3x3 convolution multiply-accumulate stage: weights 9 window samples by a signed
// kernel, scales and clamps each sum, and writes results to sequential output addresses.
module conv2d_mac #(
  parameter int DataBitWidth    = 12,
  parameter int AddressBitWidth = 17,
  parameter int CoefBitWidth    = 8,
  parameter int AccBitWidth     = 25,
  parameter int Shift           = 0,
  parameter int NoOfRows        = 5,
  parameter int NoOfColumns     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pix_valid,
  input  logic                       pix_pad,
  input  logic [DataBitWidth-1:0]    pix_in,
  input  logic                       coef_wr,
  input  logic [3:0]                 coef_addr,
  input  logic [CoefBitWidth-1:0]    coef_in,
  output logic                       wr_en,
  output logic [AddressBitWidth-1:0] WriteAddress,
  output logic [DataBitWidth-1:0]    wr_data,
  output logic                       busy,
  output logic                       done
);

  localparam int NumOut = NoOfRows * NoOfColumns;
  localparam int CntW   = $clog2(NumOut + 1);
  localparam int PixW   = DataBitWidth + 1;
  localparam int ProdW  = PixW + CoefBitWidth;

  localparam logic [CntW-1:0]            LastWin  = CntW'(NumOut - 1);
  localparam logic [CntW-1:0]            CntOne   = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [AddressBitWidth-1:0] LastAddr = AddressBitWidth'(NumOut - 1);
  localparam logic [AddressBitWidth-1:0] AddrOne  = {{(AddressBitWidth-1){1'b0}}, 1'b1};
  localparam logic signed [AccBitWidth-1:0] SatMax =
    {{(AccBitWidth-DataBitWidth){1'b0}}, {DataBitWidth{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic signed [CoefBitWidth-1:0] coef_r [0:8];
  logic [3:0]                     k_r;
  logic [CntW-1:0]                win_cnt_r;
  logic                           accept_s;
  logic                           last_win_s;
  logic signed [PixW-1:0]         pix_ext_s;
  logic signed [ProdW-1:0]        prod_s;
  logic signed [ProdW-1:0]        prod_r;
  logic                           prod_vld_r;
  logic                           prod_first_r;
  logic                           prod_last_r;
  logic signed [AccBitWidth-1:0]  acc_r;
  logic                           sum_vld_r;

  // Arithmetic shift then clamp into the unsigned pixel range.
  function automatic logic [DataBitWidth-1:0] saturate(input logic signed [AccBitWidth-1:0] sum);
    logic signed [AccBitWidth-1:0] shifted;
    shifted = sum >>> Shift;
    if (shifted[AccBitWidth-1]) begin
      saturate = {DataBitWidth{1'b0}};
    end else if (shifted > SatMax) begin
      saturate = {DataBitWidth{1'b1}};
    end else begin
      saturate = shifted[DataBitWidth-1:0];
    end
  endfunction

  // Sample acceptance and end-of-frame detection.
  always_comb begin
    accept_s   = 1'b0;
    last_win_s = 1'b0;
    if ((state_r == ST_RUN) && pix_valid) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if ((k_r == 4'd8) && (win_cnt_r == LastWin)) begin
      last_win_s = 1'b1;
    end else begin
      last_win_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && last_win_s) state_next_s = ST_FLUSH;
        else                        state_next_s = ST_RUN;
      end
      ST_FLUSH: begin
        if (wr_en && (WriteAddress == LastAddr)) state_next_s = ST_DONE;
        else                                     state_next_s = ST_FLUSH;
      end
      ST_DONE: begin
        if (start) state_next_s = ST_IDLE;
        else       state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Kernel registers, writable only while idle; out-of-range indices dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) begin
        coef_r[i] <= {CoefBitWidth{1'b0}};
      end
    end else if ((state_r == ST_IDLE) && coef_wr && (coef_addr <= 4'd8)) begin
      coef_r[coef_addr] <= coef_in;
    end else begin
      coef_r <= coef_r;
    end
  end

  // Tap index and window counter; a pix_valid gap holds both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_r       <= 4'd0;
      win_cnt_r <= {CntW{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      k_r       <= 4'd0;
      win_cnt_r <= {CntW{1'b0}};
    end else if (accept_s) begin
      if (k_r == 4'd8) begin
        k_r       <= 4'd0;
        win_cnt_r <= win_cnt_r + CntOne;
      end else begin
        k_r       <= k_r + 4'd1;
        win_cnt_r <= win_cnt_r;
      end
    end else begin
      k_r       <= k_r;
      win_cnt_r <= win_cnt_r;
    end
  end

  // Padded samples contribute zero; the pixel is widened as a non-negative signed value.
  always_comb begin
    pix_ext_s = {PixW{1'b0}};
    if (pix_pad) begin
      pix_ext_s = {PixW{1'b0}};
    end else begin
      pix_ext_s = $signed({1'b0, pix_in});
    end
    prod_s = ProdW'(pix_ext_s) * ProdW'(coef_r[k_r]);
  end

  // Product stage, tagged with its position in the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_r       <= {ProdW{1'b0}};
      prod_vld_r   <= 1'b0;
      prod_first_r <= 1'b0;
      prod_last_r  <= 1'b0;
    end else begin
      prod_r       <= prod_s;
      prod_vld_r   <= accept_s;
      prod_first_r <= (k_r == 4'd0);
      prod_last_r  <= (k_r == 4'd8);
    end
  end

  // Accumulator: the first tap reloads, so windows can run back to back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r     <= {AccBitWidth{1'b0}};
      sum_vld_r <= 1'b0;
    end else if (prod_vld_r) begin
      if (prod_first_r) begin
        acc_r <= AccBitWidth'(prod_r);
      end else begin
        acc_r <= acc_r + AccBitWidth'(prod_r);
      end
      sum_vld_r <= prod_last_r;
    end else begin
      acc_r     <= acc_r;
      sum_vld_r <= 1'b0;
    end
  end

  // Output write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_data <= {DataBitWidth{1'b0}};
    end else if (sum_vld_r) begin
      wr_en   <= 1'b1;
      wr_data <= saturate(acc_r);
    end else begin
      wr_en   <= 1'b0;
      wr_data <= wr_data;
    end
  end

  // Output address: cleared at frame start, advanced after each write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WriteAddress <= {AddressBitWidth{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      WriteAddress <= {AddressBitWidth{1'b0}};
    end else if (wr_en) begin
      WriteAddress <= WriteAddress + AddrOne;
    end else begin
      WriteAddress <= WriteAddress;
    end
  end

  // Status flags registered from the next state so they move on the transition edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next_s == ST_RUN) || (state_next_s == ST_FLUSH);
      done <= (state_next_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_conv2d_mac.sv
// Randomized self-checking bench for conv2d_mac against a window-level arithmetic model;
// a second instance with Shift=2 shares all inputs.
module tb_conv2d_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pix_valid, pix_pad, coef_wr;
  logic [11:0] pix_in;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_in;
  logic        wr_en, busy, done;
  logic [16:0] WriteAddress;
  logic [11:0] wr_data;
  logic        wr_en2, busy2, done2;
  logic [16:0] WriteAddress2;
  logic [11:0] wr_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mcoef[9];
  int cval = 0;
  int exp_d[$], exp2_d[$], exp_c[$];
  int got_a[$], got_d[$], got_c[$], got2_a[$], got2_d[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv2d_mac #(.Shift(0)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_pad(pix_pad),
    .pix_in(pix_in), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_in(coef_in),
    .wr_en(wr_en), .WriteAddress(WriteAddress), .wr_data(wr_data), .busy(busy), .done(done)
  );

  conv2d_mac #(.Shift(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_pad(pix_pad),
    .pix_in(pix_in), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_in(coef_in),
    .wr_en(wr_en2), .WriteAddress(WriteAddress2), .wr_data(wr_data2), .busy(busy2), .done(done2)
  );

  // Capture every write from both instances, with the cycle it appears in.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_a.push_back(int'(WriteAddress));
      got_d.push_back(int'(wr_data));
      got_c.push_back(cyc);
    end
    if (wr_en2 === 1'b1) begin
      got2_a.push_back(int'(WriteAddress2));
      got2_d.push_back(int'(wr_data2));
    end
  end

  function automatic int sat(input int s, input int sh);
    int r;
    r = s >>> sh;
    if (r < 0) return 0;
    if (r > 4095) return 4095;
    return r;
  endfunction

  // mode 0: centre 10*n, other taps random; mode 1: constant cval; mode 2: random
  function automatic int gen_pix(input int mode, input int n, input int k);
    if (mode == 0) return (k == 4) ? 10 * n : int'($urandom_range(0, 4095));
    if (mode == 1) return cval;
    return int'($urandom_range(0, 4095));
  endfunction

  // pad mode 0: none; 1: taps 0..2; 2: random
  function automatic int gen_pad(input int mode, input int k);
    if (mode == 1) return (k <= 2) ? 1 : 0;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic write_coef(input int k, input int v);
    @(negedge clk);
    coef_wr = 1'b1; coef_addr = 4'(k); coef_in = 8'(v);
    @(negedge clk);
    coef_wr = 1'b0;
    if (k <= 8) mcoef[k] = v;
  endtask

  task automatic load_kernel(input int v);
    for (int k = 0; k < 9; k++) write_coef(k, v);
  endtask

  task automatic load_random_kernel();
    for (int k = 0; k < 9; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
  endtask

  // Runs one frame from IDLE, checks every write and the done handshake, returns to IDLE.
  task automatic run_frame(input int mode, input int pad_mode, input int gap_pct,
                           input bit inject, input bit start_coef);
    int sum, pix, pad, t;
    exp_d.delete(); exp2_d.delete(); exp_c.delete();
    got_a.delete(); got_d.delete(); got_c.delete(); got2_a.delete(); got2_d.delete();
    @(negedge clk);
    start = 1'b1;
    if (start_coef) begin
      coef_wr = 1'b1; coef_addr = 4'd4; coef_in = 8'd3; mcoef[4] = 3;
    end
    @(negedge clk);
    start = 1'b0; coef_wr = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL busy_after_start: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    for (int n = 0; n < 25; n++) begin
      sum = 0;
      for (int k = 0; k < 9; k++) begin
        t = 0;
        while (gap_pct > 0 && t < 3 && int'($urandom_range(0, 99)) < gap_pct) begin
          pix_valid = 1'b0; pix_in = 12'($urandom); pix_pad = 1'($urandom);
          @(negedge clk);
          t++;
        end
        pix = gen_pix(mode, n, k);
        pad = gen_pad(pad_mode, k);
        pix_valid = 1'b1; pix_in = 12'(pix); pix_pad = 1'(pad);
        if (inject && n == 1 && k == 0) begin
          start = 1'b1; coef_wr = 1'b1; coef_addr = 4'd4; coef_in = 8'd77;
        end
        sum += (pad != 0 ? 0 : pix) * mcoef[k];
        if (k == 8) begin
          exp_c.push_back(cyc + 3);
          exp_d.push_back(sat(sum, 0));
          exp2_d.push_back(sat(sum, 2));
        end
        @(negedge clk);
        start = 1'b0; coef_wr = 1'b0;
      end
    end
    pix_valid = 1'b0; pix_pad = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done !== 1'b1 || done2 !== 1'b1) begin
      errors++; $display("FAIL done_timeout: done=%b done2=%b required 1", done, done2);
    end
    checks++;
    if (cyc != exp_c[24] + 1) begin
      errors++; $display("FAIL done_timing: done seen at cycle %0d required %0d", cyc, exp_c[24] + 1);
    end
    checks++;
    if (got_d.size() != 25 || got2_d.size() != 25) begin
      errors++; $display("FAIL write_count: got %0d/%0d required 25", got_d.size(), got2_d.size());
    end
    for (int i = 0; i < 25 && i < got_d.size() && i < got2_d.size(); i++) begin
      checks++;
      if (got_a[i] != i) begin
        errors++; $display("FAIL wr_addr[%0d]: got %0d required %0d", i, got_a[i], i);
      end
      checks++;
      if (got_d[i] != exp_d[i]) begin
        errors++; $display("FAIL wr_data[%0d]: got %0d required %0d", i, got_d[i], exp_d[i]);
      end
      checks++;
      if (got_c[i] != exp_c[i]) begin
        errors++; $display("FAIL wr_latency[%0d]: write at cycle %0d required %0d", i, got_c[i], exp_c[i]);
      end
      checks++;
      if (got2_a[i] != i || got2_d[i] != exp2_d[i]) begin
        errors++; $display("FAIL shift2_write[%0d]: got addr %0d data %0d required addr %0d data %0d",
                           i, got2_a[i], got2_d[i], i, exp2_d[i]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || got_d.size() != 25) begin
      errors++; $display("FAIL done_hold: done=%b busy=%b writes=%0d required 1 0 25", done, busy, got_d.size());
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_to_idle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_pad = 1'b0; pix_in = 12'd0;
    coef_wr = 1'b0; coef_addr = 4'd0; coef_in = 8'd0;
    for (int k = 0; k < 9; k++) mcoef[k] = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || WriteAddress !== 17'd0 || wr_data !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_state: wr_en=%b addr=%0d data=%0d busy=%b done=%b required all 0",
                         wr_en, WriteAddress, wr_data, busy, done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    load_kernel(0);
    write_coef(4, 1);
    write_coef(13, 50);
    run_frame(0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_all_ones();
    load_kernel(1);
    cval = 100;
    run_frame(1, 0, 0, 1'b0, 1'b0);
    run_frame(1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    load_kernel(127);
    cval = 4095;
    run_frame(1, 0, 0, 1'b0, 1'b0);
    load_kernel(-128);
    run_frame(1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_shift_gaps();
    load_kernel(1);
    cval = 7;
    run_frame(1, 0, 30, 1'b0, 1'b0);
  endtask

  task automatic test_control();
    load_random_kernel();
    run_frame(2, 2, 0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_frame(2, 2, 0, 1'b0, 1'b0);
    load_random_kernel();
    run_frame(2, 2, 25, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    load_kernel(0);
    write_coef(4, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 22; s++) begin
      pix_valid = 1'b1; pix_in = 12'($urandom); pix_pad = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) mcoef[k] = 0;
    checks++;
    if (wr_en !== 1'b0 || WriteAddress !== 17'd0 || wr_data !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: wr_en=%b addr=%0d data=%0d busy=%b done=%b required all 0",
                         wr_en, WriteAddress, wr_data, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    got_d.delete(); got_a.delete(); got_c.delete(); got2_a.delete(); got2_d.delete();
    repeat (12) begin
      pix_valid = 1'b1; pix_in = 12'($urandom);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    checks++;
    if (got_d.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: writes=%0d busy=%b done=%b required 0 0 0", got_d.size(), busy, done);
    end
    run_frame(2, 0, 0, 1'b0, 1'b0);
    write_coef(4, 1);
    run_frame(0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_ones();
    test_saturation();
    test_shift_gaps();
    test_control();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
